// File: rtl/universal_gate_checker_pkg.sv
// rtl/universal_gate_checker_pkg.sv - shared states, vector count and truth-table constants
package universal_gate_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int NUM_VEC = 4;

    // Expected y per vector index {a,b}; bit0 is (0,0), bit3 is (1,1)
    localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
    localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;

    // Bits needed to hold 0..max_val, never less than one
    function automatic int count_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/universal_gate_checker_settle_timer.sv
// rtl/universal_gate_checker_settle_timer.sv - loadable down-counter flagging the last settle cycle
module universal_gate_checker_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority; decrement stops at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The cycle the count reads one is the last settle cycle
    assign expire = (count_q == W'(1));

endmodule

// File: rtl/universal_gate_checker.sv
// rtl/universal_gate_checker.sv - sweeps a/b over all four vectors and scores the gate output
module universal_gate_checker
    import universal_gate_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ROUNDS        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       exp_tt,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_mask,
    output logic [CNT_W-1:0] err_count
);

    localparam int                   TIMER_W     = count_width(SETTLE_CYCLES);
    localparam logic [TIMER_W-1:0]   SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES);
    localparam int                   ROUND_W     = count_width(ROUNDS - 1);
    localparam logic [ROUND_W-1:0]   LAST_ROUND  = ROUND_W'(ROUNDS - 1);
    // With no settle time a freshly driven vector is sampled in the very next cycle
    localparam state_e               VEC_ENTRY   = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

    state_e             state_q, state_d;
    logic [3:0]         exp_q, exp_d;
    logic [1:0]         idx_q, idx_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [1:0]         ab_q, ab_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [3:0]         fail_mask_q, fail_mask_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               timer_load;
    logic               timer_dec;
    logic               timer_expire;

    universal_gate_checker_settle_timer #(
        .W (TIMER_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .dec      (timer_dec),
        .expire   (timer_expire)
    );

    // Next-state, vector sequencing and scoreboard update
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        idx_d       = idx_q;
        round_d     = round_q;
        ab_d        = ab_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        if ((state_q != ST_IDLE) && abort) begin
            // Cancel keeps partial scores but never reports a result
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ab_d    = 2'b00;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        exp_d       = exp_tt;
                        fail_mask_d = '0;
                        err_count_d = '0;
                        pass_d      = 1'b0;
                        idx_d       = 2'd0;
                        round_d     = '0;
                        ab_d        = 2'b00;
                        busy_d      = 1'b1;
                        timer_load  = 1'b1;
                        state_d     = VEC_ENTRY;
                    end
                end
                ST_SETTLE: begin
                    if (timer_expire) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (y_in != exp_q[idx_q]) begin
                        fail_mask_d[idx_q] = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        ab_d       = idx_q + 2'd1;
                        timer_load = 1'b1;
                        state_d    = VEC_ENTRY;
                    end else if (round_q != LAST_ROUND) begin
                        idx_d      = 2'd0;
                        round_d    = round_q + ROUND_W'(1);
                        ab_d       = 2'b00;
                        timer_load = 1'b1;
                        state_d    = VEC_ENTRY;
                    end else begin
                        ab_d    = 2'b00;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // fail_mask_q already holds the last sample's contribution here
                    done_d  = 1'b1;
                    pass_d  = (fail_mask_q == 4'b0000);
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exp_q       <= 4'b0000;
            idx_q       <= 2'd0;
            round_q     <= '0;
            ab_q        <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'b0000;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            idx_q       <= idx_d;
            round_q     <= round_d;
            ab_q        <= ab_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    assign a_out     = ab_q[1];
    assign b_out     = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_universal_gate_checker.sv
// tb/tb_universal_gate_checker.sv - randomized and directed checks of universal_gate_checker against a truth-table model
module tb_universal_gate_checker;

    localparam int NI = 3;

    // Gate behaviours placed on y_in
    localparam int MD_NAND   = 0;
    localparam int MD_NOR    = 1;
    localparam int MD_STUCK1 = 2;
    localparam int MD_TABLE  = 3;

    logic       clk;
    logic       rst_n;
    logic       start     [NI];
    logic       abort     [NI];
    logic [3:0] exp_tt    [NI];
    logic       y_in      [NI];
    logic       a_out     [NI];
    logic       b_out     [NI];
    logic       busy      [NI];
    logic       done      [NI];
    logic       pass      [NI];
    logic [3:0] fail_mask [NI];
    logic [7:0] err_count [NI];
    int         mode      [NI];
    logic [3:0] tbl       [NI];

    int errors;
    int checks;

    function automatic int s_of(input int g);
        return (g == 2) ? 0 : 2;
    endfunction

    function automatic int r_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    function automatic logic gate_out(input int md, input logic [3:0] t, input logic a, input logic b);
        logic [1:0] v;
        v = {a, b};
        case (md)
            MD_NAND:   return ~(a & b);
            MD_NOR:    return ~(a | b);
            MD_STUCK1: return 1'b1;
            default:   return t[v];
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign y_in[g] = gate_out(mode[g], tbl[g], a_out[g], b_out[g]);

        universal_gate_checker #(
            .SETTLE_CYCLES ((g == 2) ? 0 : 2),
            .ROUNDS        ((g == 1) ? 3 : 1),
            .CNT_W         (8)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .abort     (abort[g]),
            .exp_tt    (exp_tt[g]),
            .y_in      (y_in[g]),
            .a_out     (a_out[g]),
            .b_out     (b_out[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .fail_mask (fail_mask[g]),
            .err_count (err_count[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input int g, input string tag);
        check($sformatf("g%0d %s busy", g, tag), 32'(busy[g]), 32'd0);
        check($sformatf("g%0d %s done", g, tag), 32'(done[g]), 32'd0);
        check($sformatf("g%0d %s ab", g, tag), 32'({a_out[g], b_out[g]}), 32'd0);
    endtask

    // Full run scored against the truth-table model; start may be re-pulsed at cycle repulse
    task automatic run_check(input int g, input int md, input logic [3:0] t, input logic [3:0] e, input int repulse);
        int         per;
        int         total;
        int         n_done;
        int         err_exp;
        int         vi;
        logic [3:0] mask_exp;
        per   = s_of(g) + 1;
        total = 4 * r_of(g) * per;
        n_done = total + 1;
        for (int v = 0; v < 4; v++) begin
            mask_exp[v] = gate_out(md, t, v[1], v[0]) ^ e[v];
        end
        err_exp = r_of(g) * $countones(mask_exp);
        if (err_exp > 255) err_exp = 255;
        mode[g]   = md;
        tbl[g]    = t;
        exp_tt[g] = e;
        @(negedge clk);
        start[g] = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= n_done + 1; n++) begin
            @(negedge clk);
            start[g] = 1'b0;
            if (n == 0) begin
                check($sformatf("g%0d pass cleared", g), 32'(pass[g]), 32'd0);
                check($sformatf("g%0d mask cleared", g), 32'(fail_mask[g]), 32'd0);
                check($sformatf("g%0d err cleared", g), 32'(err_count[g]), 32'd0);
            end
            if (n < total) begin
                vi = (n / per) % 4;
                check($sformatf("g%0d busy n%0d", g, n), 32'(busy[g]), 32'd1);
                check($sformatf("g%0d done n%0d", g, n), 32'(done[g]), 32'd0);
                check($sformatf("g%0d ab n%0d", g, n), 32'({a_out[g], b_out[g]}), 32'(vi));
            end else if (n == total) begin
                check_idle_outputs(g, "final");
            end else if (n == n_done) begin
                check($sformatf("g%0d done pulse", g), 32'(done[g]), 32'd1);
                check($sformatf("g%0d busy at done", g), 32'(busy[g]), 32'd0);
                check($sformatf("g%0d pass", g), 32'(pass[g]), 32'(mask_exp == 4'b0000));
                check($sformatf("g%0d fail_mask", g), 32'(fail_mask[g]), 32'(mask_exp));
                check($sformatf("g%0d err_count", g), 32'(err_count[g]), 32'(err_exp));
            end else begin
                check($sformatf("g%0d done one cycle", g), 32'(done[g]), 32'd0);
                check($sformatf("g%0d pass held", g), 32'(pass[g]), 32'(mask_exp == 4'b0000));
            end
            if (n == repulse) start[g] = 1'b1;
        end
        start[g] = 1'b0;
    endtask

    initial begin
        logic [3:0] rt;
        logic [3:0] re;
        int         rg;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        for (int g = 0; g < NI; g++) begin
            start[g]  = 1'b0;
            abort[g]  = 1'b0;
            exp_tt[g] = 4'b0000;
            mode[g]   = MD_NAND;
            tbl[g]    = 4'b0000;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check_idle_outputs(g, "reset");
            check($sformatf("g%0d reset pass", g), 32'(pass[g]), 32'd0);
            check($sformatf("g%0d reset mask", g), 32'(fail_mask[g]), 32'd0);
            check($sformatf("g%0d reset err", g), 32'(err_count[g]), 32'd0);
        end
        rst_n = 1'b1;

        // NAND gate, NAND table, start re-pulsed mid run
        run_check(0, MD_NAND, 4'b0000, 4'b0111, 3);
        // NOR gate against NAND table, start pulsed while in DONE
        run_check(0, MD_NOR, 4'b0000, 4'b0111, 12);
        // Stuck-at-1 output over three rounds
        run_check(1, MD_STUCK1, 4'b0000, 4'b0111, -1);
        // No settle time
        run_check(2, MD_NAND, 4'b0000, 4'b0111, -1);

        // Abort during vector 2 settle keeps partial scores and never pulses done
        mode[0]   = MD_NOR;
        exp_tt[0] = 4'b0111;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            start[0] = 1'b0;
            abort[0] = (n == 6);
            if (n == 7) begin
                check_idle_outputs(0, "abort");
                check("g0 abort pass", 32'(pass[0]), 32'd0);
                check("g0 abort mask", 32'(fail_mask[0]), 32'h2);
                check("g0 abort err", 32'(err_count[0]), 32'd1);
            end else if (n > 7) begin
                check($sformatf("g0 no done after abort n%0d", n), 32'(done[0]), 32'd0);
            end
        end
        abort[0] = 1'b0;
        run_check(0, MD_NAND, 4'b0000, 4'b0111, -1);

        // Start and abort together in idle: abort wins
        @(negedge clk);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            start[0] = 1'b0;
            abort[0] = 1'b0;
            check_idle_outputs(0, $sformatf("start+abort n%0d", n));
        end

        // Asynchronous reset in the middle of a sample cycle
        mode[0]   = MD_NOR;
        exp_tt[0] = 4'b0111;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        check("g0 pre-reset err", 32'(err_count[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "async reset");
        check("g0 async reset mask", 32'(fail_mask[0]), 32'd0);
        check("g0 async reset err", 32'(err_count[0]), 32'd0);
        check("g0 async reset pass", 32'(pass[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(0, MD_NAND, 4'b0000, 4'b0111, -1);

        // Random gate tables against random expectations on every build
        for (int it = 0; it < 8; it++) begin
            rg = int'($urandom_range(0, NI - 1));
            rt = 4'($urandom);
            re = 4'($urandom);
            run_check(rg, MD_TABLE, rt, re, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_gate_checker.md
Name: universal_gate_checker

Overview:
Self-timed stimulus/response checker for the two-input universal gates (NAND, NOR) built from switch-level primitives. It drives the gate's a/b inputs through all four combinations, waits a settle time, and samples the gate output y. It compares each sample against an expected truth table and reports pass/fail, a per-vector fail mask and a mismatch count. It sits beside the gate under test on the challenge board/bench, at the consuming end of the gate's a/b→y interface.

Parameters:
SETTLE_CYCLES, 2, clocks held after driving a vector before sampling y_in; 0 legal (sample in first cycle after drive)
ROUNDS, 1, number of full 4-vector sweeps per run; min 1
CNT_W, 8, width of err_count

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a run; sampled only in IDLE
abort  input  1  cancel run in progress
exp_tt  input  4  expected y per vector index {a,b}: bit0=(0,0) … bit3=(1,1); latched on accepted start
y_in  input  1  gate output under test
a_out  output  1  gate input a (MSB of vector index)
b_out  output  1  gate input b (LSB of vector index)
busy  output  1  run in progress
done  output  1  one-cycle pulse at run end
pass  output  1  last completed run had zero mismatches; held until next accepted start
fail_mask  output  4  OR over rounds of per-vector mismatches, bit i = vector i
err_count  output  CNT_W  total mismatches in run, saturating at all-ones

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset asserted, including mid-run, forces: state IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 and abort=0 → latch exp_tt, clear fail_mask/err_count/pass, idx=0, round=0, drive {a_out,b_out}=00, busy=1. Next state: SETTLE with timer=SETTLE_CYCLES, or SAMPLE directly if SETTLE_CYCLES=0.
- SETTLE: timer decrements each cycle. The cycle it reads 1 → SAMPLE. a_out/b_out held.
- SAMPLE, one cycle, a_out/b_out still held: if y_in != exp_tt[idx], set fail_mask[idx] and increment err_count (saturating).
  - idx<3: idx+1, drive new vector, go SETTLE (or SAMPLE if SETTLE_CYCLES=0).
  - idx==3 and round<ROUNDS-1: idx=0, round+1, drive 00, go SETTLE/SAMPLE.
  - otherwise: go DONE.
- Per-vector time = SETTLE_CYCLES+1 cycles. Vector k's drive appears the cycle after the previous SAMPLE.
- DONE, one cycle: done=1, pass=(fail_mask==0) using the final value, busy=0, a_out/b_out=00. Next state IDLE.
- Latency: start accepted at edge 0 → done high for one cycle at edge 4·ROUNDS·(SETTLE_CYCLES+1)+1.
- start while busy or in DONE: ignored, no queuing.
- abort in any non-IDLE state: next state IDLE, busy=0, a_out/b_out=00, pass=0, no done pulse. fail_mask/err_count keep partial values.
- abort and start together in IDLE: abort wins, no run.
- abort in the same cycle as the final SAMPLE: abort wins, no done.
- y_in is treated as settled in SAMPLE; no synchroniser (gate shares the clock domain).

Decomposition:
- Shared header: state encodings, NUM_VEC=4, truth-table constants TT_NAND=4'b0111, TT_NOR=4'b0001.
- One sub-module, settle_timer: load/decrement down-counter with expire flag, width clog2(SETTLE_CYCLES+1). FSM, scoreboard and outputs stay in the top.

Test Plan:
- Behavioural NAND on y_in, exp_tt=TT_NAND, SETTLE_CYCLES=2, ROUNDS=1, start pulse → a/b sequence 00,01,10,11 each held 3 cycles; done at edge 13; pass=1, fail_mask=0000, err_count=0.
- NOR gate, exp_tt=TT_NAND → pass=0, fail_mask=0110, err_count=2.
- y_in stuck at 1, exp_tt=TT_NAND, ROUNDS=3 → fail_mask=1000, err_count=3, done at edge 37.
- Abort asserted during round 0 vector 2 SETTLE → busy=0 next cycle, a/b=00, no done, pass=0. A later start gives a clean full run.
- start re-pulsed while busy, and start+abort together in IDLE → no restart, timing unchanged; no run started, busy stays 0.
- rst_n low mid-SAMPLE, then released → all outputs at reset values immediately (asynchronous). Next start runs normally. SETTLE_CYCLES=0 build: done at edge 5.
